// File: rtl/register_file.sv
// register_file: integer register file, 32 x DATA_WIDTH, x0 hardwired to zero
//   clk       : write clock, rising edge
//   rst_n     : asynchronous reset, active-high despite the name; clears x1..x31
//   rs1, rs2  : read addresses
//   rs1_data  : combinational contents of rs1 (0 when rs1 is x0)
//   rs2_data  : combinational contents of rs2 (0 when rs2 is x0)
//   reg_write : write enable for rd
//   rd        : write address; writes to x0 are discarded
//   rd_data   : write data
module register_file #(
    parameter  int DATA_WIDTH    = 32,
    localparam int REG_BUS_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [REG_BUS_WIDTH-1:0] rs1,
    input  logic [REG_BUS_WIDTH-1:0] rs2,
    output logic [DATA_WIDTH-1:0]    rs1_data,
    output logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic                     reg_write,
    input  logic [REG_BUS_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0]    rd_data
);
    localparam int NREG = 2 ** REG_BUS_WIDTH;

    // x0 has no storage; the array starts at x1
    logic [DATA_WIDTH-1:0] regs_q [1:NREG-1];
    logic [DATA_WIDTH-1:0] regs_d [1:NREG-1];

    always_comb begin
        regs_d = regs_q;
        if (reg_write && rd != '0) regs_d[rd] = rd_data;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) regs_q <= '{default: '0};
        else       regs_q <= regs_d;
    end

    // No write bypass: reads see stored state only
    assign rs1_data = (rs1 == '0) ? '0 : regs_q[rs1];
    assign rs2_data = (rs2 == '0) ? '0 : regs_q[rs2];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: randomized scoreboard bench for register_file against an array model
module tb_register_file;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [31:0] rd_data = '0;
    logic        reg_write = 1'b0;
    logic [31:0] rs1_data, rs2_data;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
        int          id;
    } exp_t;

    exp_t        sb[$];
    logic        vld = 1'b0;
    logic [31:0] model [32];
    int          n_chk = 0, n_fail = 0, id = 0;

    register_file #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .reg_write(reg_write), .rd(rd), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // One cycle: drive between edges, queue the read results expected before the
    // coming edge, then let the model take the write that edge will perform.
    task automatic cyc(input logic r, input logic we, input logic [4:0] a_w,
                       input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = r; reg_write = we; rd = a_w; rd_data = d; rs1 = a1; rs2 = a2;
        if (r) foreach (model[i]) model[i] = 32'h0;
        x.e1 = (a1 == 0) ? 32'h0 : model[a1];
        x.e2 = (a2 == 0) ? 32'h0 : model[a2];
        x.id = id++;
        sb.push_back(x);
        vld = 1'b1;
        if (!r && we && a_w != 0) model[a_w] = d;
    endtask

    always @(negedge clk) begin
        if (vld) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL scoreboard_empty: no expected entry at time %0t", $time);
            end else begin
                exp_t x;
                x = sb.pop_front();
                n_chk++;
                if (rs1_data !== x.e1) begin
                    n_fail++;
                    $display("FAIL rs1_data step %0d rs1=%0d: got %h expected %h", x.id, rs1, rs1_data, x.e1);
                end
                n_chk++;
                if (rs2_data !== x.e2) begin
                    n_fail++;
                    $display("FAIL rs2_data step %0d rs2=%0d: got %h expected %h", x.id, rs2, rs2_data, x.e2);
                end
            end
        end
    end

    initial begin
        logic [4:0]  a;
        logic [31:0] d;
        foreach (model[i]) model[i] = 32'hx;
        #2 rst_n = 1'b1;
        cyc(1, 1, 5'd3, 32'h1111_1111, 5'd3, 5'd0);
        cyc(1, 0, 5'd0, 32'h0, 5'd3, 5'd31);
        for (int i = 0; i < 32; i++) cyc(0, 0, 5'(i), 32'hFFFF_FFFF, 5'(i), 5'(31 - i));
        cyc(0, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
        cyc(0, 0, 5'd0, 32'h0, 5'd5, 5'd5);
        cyc(0, 1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
        cyc(0, 0, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
        cyc(0, 0, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd5);
        cyc(0, 1, 5'd7, 32'h0000_0001, 5'd7, 5'd7);
        cyc(0, 0, 5'd7, 32'h5A5A_5A5A, 5'd7, 5'd7);
        cyc(0, 0, 5'd0, 32'h0, 5'd7, 5'd5);
        for (int i = 0; i < 10; i++) begin
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            cyc(0, 1, a, d, a, 5'($urandom_range(0, 31)));
            cyc(0, 0, 5'($urandom_range(0, 31)), $urandom, a, 5'($urandom_range(0, 31)));
        end
        for (int i = 0; i < 200; i++)
            cyc(0, 1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
        cyc(0, 1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd7);
        cyc(0, 0, 5'd0, 32'h0, 5'd31, 5'd31);
        cyc(1, 1, 5'd31, 32'h0000_0005, 5'd31, 5'd7);
        cyc(1, 1, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd31);
        cyc(0, 1, 5'd9, 32'h0BAD_CAFE, 5'd9, 5'd31);
        cyc(0, 0, 5'd0, 32'h0, 5'd9, 5'd31);
        for (int i = 0; i < 50; i++)
            cyc(0, 1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
        @(posedge clk);
        #1 vld = 1'b0;
        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/register_file.md
# register_file

Integer register file for the core_l1 pipeline: 32 general-purpose registers of DATA_WIDTH bits, two combinational read ports (rs1, rs2) and one synchronous write port (rd). Register x0 is hardwired to zero. Decode/operand-fetch reads source operands from it; write-back writes results into it.

## Interface
Parameters:
- DATA_WIDTH, default 32, width of each register and of all data ports.
- REG_BUS_WIDTH, derived, $clog2(DATA_WIDTH) (5 at default), register address width. Register count is 2**REG_BUS_WIDTH (32). Not overridable.

Ports:
- clk  input  1  single clock; all writes on rising edge.
- rst_n  input  1  reset, asynchronous, active-high (asserted when 1; name kept per codebase convention).
- rs1  input  REG_BUS_WIDTH  read port 1 address.
- rs2  input  REG_BUS_WIDTH  read port 2 address.
- rs1_data  output  DATA_WIDTH  contents of register rs1.
- rs2_data  output  DATA_WIDTH  contents of register rs2.
- reg_write  input  1  write enable for port rd.
- rd  input  REG_BUS_WIDTH  write address.
- rd_data  input  DATA_WIDTH  write data.

## Operation
- Storage: registers x1..x31, each DATA_WIDTH bits. x0 has no storage; always reads 0.
- Read: rs1_data = (rs1 == 0) ? 0 : reg[rs1]; same for rs2/rs2_data. Purely combinational, no clock involvement; both ports independent, may address the same register.
- Write: at rising clk, if reg_write == 1 and rd != 0 and reset not asserted, reg[rd] <= rd_data. Writes with rd == 0 are discarded.
- reg_write == 0: no register changes regardless of rd/rd_data.
- Reset: while rst_n == 1, all registers x1..x31 cleared to 0 immediately (asynchronous) and held at 0; writes ignored. Outputs therefore read 0 for every address during and right after reset.
- No internal write-to-read bypass: a read of the register being written in the same cycle returns the old value until the clock edge, then the new value.

## Timing
- Read latency: combinational; outputs valid within same-cycle propagation after rs1/rs2 or stored contents change.
- Write latency: one edge; new value visible on read ports immediately after the rising edge that samples reg_write=1.
- Reset assertion mid-operation: clears contents asynchronously without waiting for clk; a write coincident with reset assertion is lost.
- Reset deassertion: first write accepted at the first rising edge where rst_n == 0.
- No X propagation from stored state: every readable register has a defined value after reset.

## Test plan
- Reset then sweep: assert rst_n=1 for 2 cycles, release; for addresses 0..31 on rs1 and rs2 -> rs1_data/rs2_data = 0x00000000 for all.
- Basic write/read: write rd=5, rd_data=0xDEADBEEF with reg_write=1 for one edge; set rs1=5 -> rs1_data=0xDEADBEEF; rs2=5 -> rs2_data=0xDEADBEEF.
- x0 protection: write rd=0, rd_data=0x12345678 -> rs1=0 and rs2=0 read 0x00000000.
- Write-enable gating: rd=7, rd_data=0xA5A5A5A5, reg_write=0 over an edge -> rs1=7 reads previous value (0 after reset); then x7 written 0x1 with reg_write=1 -> reads 0x00000001; rd_data then changed with reg_write=0 -> stays 0x00000001.
- Random sequence: 10 writes of random data to random addresses 0..31, each followed by rs1 read of same address -> equals written data, or 0 when address is 0; previously written other registers unchanged.
- Async reset mid-run: after writing x31=0xFFFFFFFF, assert rst_n between clock edges -> rs1=31 reads 0 before next rising edge; write during reset ignored.
